// File: rtl/cipher_sequencer_pkg.sv
// rtl/cipher_sequencer_pkg.sv - shared types for the cipher byte sequencer
package cipher_sequencer_pkg;

    typedef enum logic [2:0] {
        SQ_IDLE    = 3'b000,
        SQ_RESEED  = 3'b001,
        SQ_REQUEST = 3'b010,
        SQ_AWAIT   = 3'b011,
        SQ_OUTPUT  = 3'b100,
        SQ_ERROR   = 3'b101
    } sequencer_state_t;

    // Counter width able to hold TIMEOUT_CYCLES-1; never narrower than one bit.
    function automatic int timer_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/seq_timeout_timer.sv
// rtl/seq_timeout_timer.sv - clearable saturating up-counter with expiry flag
module seq_timeout_timer
    import cipher_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic first_o,
    output logic expired_o
);
    localparam int W = timer_width(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LAST)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign first_o   = (count_q == '0);
    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/cipher_sequencer.sv
// rtl/cipher_sequencer.sv - sequences plaintext bytes through the keystream XOR
module cipher_sequencer
    import cipher_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int COUNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [7:0]         in_byte,
    input  logic               in_last,
    output logic               in_ready,
    output logic               hash_req,
    input  logic               hash_valid,
    input  logic [7:0]         hash_byte,
    input  logic               hash_exhausted,
    output logic               hash_reseed,
    output logic               out_valid,
    output logic [7:0]         out_byte,
    output logic               out_last,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] byte_count,
    output logic               err_timeout,
    input  logic               err_clear
);
    sequencer_state_t   state_q, state_d;
    logic [7:0]         pt_byte_q, pt_byte_d;
    logic               pt_last_q, pt_last_d;
    logic [7:0]         out_byte_q, out_byte_d;
    logic               out_last_q, out_last_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               tmr_clr, tmr_en, tmr_first, tmr_expired;

    // One timer serves both waits; it restarts from zero on entry to either.
    assign tmr_clr = (state_q == SQ_IDLE) || (state_q == SQ_REQUEST);
    assign tmr_en  = (state_q == SQ_RESEED) || (state_q == SQ_AWAIT);

    seq_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .first_o   (tmr_first),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        pt_byte_d  = pt_byte_q;
        pt_last_d  = pt_last_q;
        out_byte_d = out_byte_q;
        out_last_d = out_last_q;
        count_d    = count_q;
        case (state_q)
            SQ_IDLE: begin
                if (in_valid) begin
                    pt_byte_d = in_byte;
                    pt_last_d = in_last;
                    state_d   = hash_exhausted ? SQ_RESEED : SQ_REQUEST;
                end
            end
            SQ_RESEED: begin
                if (!hash_exhausted) begin
                    state_d = SQ_REQUEST;
                end else if (tmr_expired) begin
                    state_d = SQ_ERROR;
                end
            end
            SQ_REQUEST: state_d = SQ_AWAIT;
            SQ_AWAIT: begin
                // A keystream byte arriving on the expiry cycle still counts.
                if (hash_valid) begin
                    out_byte_d = pt_byte_q ^ hash_byte;
                    out_last_d = pt_last_q;
                    state_d    = SQ_OUTPUT;
                end else if (tmr_expired) begin
                    state_d = SQ_ERROR;
                end
            end
            SQ_OUTPUT: begin
                if (out_ready) begin
                    count_d = count_q + COUNT_W'(1);
                    state_d = SQ_IDLE;
                end
            end
            SQ_ERROR: begin
                if (err_clear) begin
                    state_d = SQ_IDLE;
                end
            end
            default: state_d = SQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SQ_IDLE;
            pt_byte_q  <= '0;
            pt_last_q  <= 1'b0;
            out_byte_q <= '0;
            out_last_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pt_byte_q  <= pt_byte_d;
            pt_last_q  <= pt_last_d;
            out_byte_q <= out_byte_d;
            out_last_q <= out_last_d;
            count_q    <= count_d;
        end
    end

    assign in_ready    = (state_q == SQ_IDLE);
    assign hash_req    = (state_q == SQ_REQUEST);
    assign hash_reseed = (state_q == SQ_RESEED) && tmr_first;
    assign out_valid   = (state_q == SQ_OUTPUT);
    assign err_timeout = (state_q == SQ_ERROR);
    assign out_byte    = out_byte_q;
    assign out_last    = out_last_q;
    assign byte_count  = count_q;

endmodule

// File: tb/tb_cipher_sequencer.sv
// tb/tb_cipher_sequencer.sv - directed self-checking bench for cipher_sequencer
`timescale 1ns/1ps
module tb_cipher_sequencer;
    localparam int TO = 64;
    localparam int CW = 4;

    logic          clk, rst_n;
    logic          in_valid, in_last, in_ready;
    logic [7:0]    in_byte, hash_byte, out_byte;
    logic          hash_req, hash_valid, hash_exhausted, hash_reseed;
    logic          out_valid, out_last, out_ready;
    logic [CW-1:0] byte_count;
    logic          err_timeout, err_clear;

    int            errors = 0;
    int            checks = 0;
    int            req_cnt = 0;
    int            rs_cnt = 0;
    logic [CW-1:0] exp_count = '0;

    cipher_sequencer #(.TIMEOUT_CYCLES(TO), .COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last), .in_ready(in_ready),
        .hash_req(hash_req), .hash_valid(hash_valid), .hash_byte(hash_byte),
        .hash_exhausted(hash_exhausted), .hash_reseed(hash_reseed),
        .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last), .out_ready(out_ready),
        .byte_count(byte_count), .err_timeout(err_timeout), .err_clear(err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (hash_req)    req_cnt++;
            if (hash_reseed) rs_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_byte(input logic [7:0] b, input logic l, input logic [7:0] ks, input int dly,
                            output logic [7:0] ob, output logic ol, output bit ok);
        int n;
        ok = 1'b1; ob = '0; ol = 1'b0; n = 0;
        while (!in_ready && n < 200) begin step(); n++; end
        in_valid = 1'b1; in_byte = b; in_last = l;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        if (hash_req !== 1'b1) ok = 1'b0;
        repeat (dly) step();
        hash_valid = 1'b1; hash_byte = ks;
        step();
        hash_valid = 1'b0;
        if (out_valid !== 1'b1) ok = 1'b0;
        ob = out_byte; ol = out_last;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
        exp_count++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_byte = '0; in_last = 1'b0;
        hash_valid = 1'b0; hash_byte = '0; hash_exhausted = 1'b0;
        out_ready = 1'b0; err_clear = 1'b0;
        repeat (2) step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (hash_req !== 1'b0) begin errors++; $display("FAIL reset_hash_req: got %b want 0", hash_req); end
        checks++; if (hash_reseed !== 1'b0) begin errors++; $display("FAIL reset_hash_reseed: got %b want 0", hash_reseed); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_byte !== 8'h00) begin errors++; $display("FAIL reset_out_byte: got %h want 00", out_byte); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        checks++; if (byte_count !== 4'd0) begin errors++; $display("FAIL reset_byte_count: got %0d want 0", byte_count); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err_timeout: got %b want 0", err_timeout); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ignored_inputs();
        int rq0;
        rq0 = req_cnt;
        hash_valid = 1'b1; hash_byte = 8'h77; err_clear = 1'b1;
        step();
        hash_valid = 1'b0; err_clear = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL idle_ignore: got in_ready=%b out_valid=%b err=%b want 1 0 0", in_ready, out_valid, err_timeout); end
        checks++; if (req_cnt - rq0 !== 0) begin errors++; $display("FAIL idle_ignore_req: got %0d want 0", req_cnt - rq0); end
    endtask

    task automatic test_basic();
        logic [7:0] ob; logic ol; bit ok; int rq0;
        rq0 = req_cnt;
        run_byte(8'hA5, 1'b0, 8'h3C, 2, ob, ol, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_protocol: got %b want 1", ok); end
        checks++; if (ob !== 8'h99) begin errors++; $display("FAIL basic_out_byte: got %h want 99", ob); end
        checks++; if (byte_count !== 4'd1) begin errors++; $display("FAIL basic_byte_count: got %0d want 1", byte_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
        checks++; if (req_cnt - rq0 !== 1) begin errors++; $display("FAIL basic_req_count: got %0d want 1", req_cnt - rq0); end
    endtask

    task automatic test_reseed();
        int rq0, rs0;
        rq0 = req_cnt; rs0 = rs_cnt;
        hash_exhausted = 1'b1;
        in_valid = 1'b1; in_byte = 8'h5A; in_last = 1'b0;
        step();
        in_valid = 1'b0;
        checks++; if (hash_reseed !== 1'b1) begin errors++; $display("FAIL reseed_pulse: got %b want 1", hash_reseed); end
        repeat (2) step();
        hash_exhausted = 1'b0;
        step();
        checks++; if (hash_req !== 1'b1) begin errors++; $display("FAIL reseed_then_req: got %b want 1", hash_req); end
        step();
        hash_valid = 1'b1; hash_byte = 8'hFF;
        step();
        hash_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_byte !== 8'hA5) begin
            errors++; $display("FAIL reseed_out: got valid=%b byte=%h want 1 a5", out_valid, out_byte); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_count++;
        checks++; if (rs_cnt - rs0 !== 1) begin errors++; $display("FAIL reseed_count: got %0d want 1", rs_cnt - rs0); end
        checks++; if (req_cnt - rq0 !== 1) begin errors++; $display("FAIL reseed_req_count: got %0d want 1", req_cnt - rq0); end
        checks++; if (byte_count !== exp_count) begin errors++; $display("FAIL reseed_byte_count: got %0d want %0d", byte_count, exp_count); end
    endtask

    task automatic test_timeout();
        int rq0;
        in_valid = 1'b1; in_byte = 8'h11; in_last = 1'b0;
        step();
        in_valid = 1'b0;
        checks++; if (hash_req !== 1'b1) begin errors++; $display("FAIL timeout_req: got %b want 1", hash_req); end
        rq0 = req_cnt;
        repeat (TO) step();
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", err_timeout); end
        step();
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_rise: got %b want 1", err_timeout); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL timeout_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        hash_valid = 1'b1; hash_byte = 8'h22;
        step();
        hash_valid = 1'b0;
        checks++; if (err_timeout !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL error_hold: got err=%b out_valid=%b want 1 0", err_timeout, out_valid); end
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        checks++; if (in_ready !== 1'b1 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL err_clear: got in_ready=%b err=%b want 1 0", in_ready, err_timeout); end
        checks++; if (byte_count !== exp_count) begin errors++; $display("FAIL err_byte_count: got %0d want %0d", byte_count, exp_count); end
        checks++; if (req_cnt - rq0 !== 0) begin errors++; $display("FAIL err_no_req: got %0d want 0", req_cnt - rq0); end
    endtask

    task automatic test_timeout_race();
        in_valid = 1'b1; in_byte = 8'hF0; in_last = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (TO) step();
        hash_valid = 1'b1; hash_byte = 8'h0F;
        step();
        hash_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || err_timeout !== 1'b0 || out_byte !== 8'hFF) begin
            errors++; $display("FAIL race_hash_wins: got valid=%b err=%b byte=%h want 1 0 ff", out_valid, err_timeout, out_byte); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_count++;
        checks++; if (byte_count !== exp_count) begin errors++; $display("FAIL race_byte_count: got %0d want %0d", byte_count, exp_count); end
    endtask

    task automatic test_stall();
        int rq0; bit stable;
        in_valid = 1'b1; in_byte = 8'h12; in_last = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        hash_valid = 1'b1; hash_byte = 8'h34;
        step();
        hash_valid = 1'b0;
        rq0 = req_cnt; stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_byte !== 8'h26) stable = 1'b0;
            step();
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL stall_stable: got %b want 1", stable); end
        checks++; if (byte_count !== exp_count) begin errors++; $display("FAIL stall_count_held: got %0d want %0d", byte_count, exp_count); end
        checks++; if (req_cnt - rq0 !== 0) begin errors++; $display("FAIL stall_no_req: got %0d want 0", req_cnt - rq0); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_count++;
        checks++; if (byte_count !== exp_count) begin errors++; $display("FAIL stall_release: got %0d want %0d", byte_count, exp_count); end
    endtask

    task automatic test_stream();
        logic [7:0] pt [3];
        logic [7:0] ks [3];
        logic [7:0] ct [3];
        logic       lst [3];
        int         dl [3];
        logic [7:0] ob; logic ol; bit ok;
        pt = '{8'h01, 8'h80, 8'hFF};
        ks = '{8'h10, 8'h08, 8'h0F};
        ct = '{8'h11, 8'h88, 8'hF0};
        lst = '{1'b0, 1'b0, 1'b1};
        dl = '{1, 3, 5};
        for (int i = 0; i < 3; i++) begin
            run_byte(pt[i], lst[i], ks[i], dl[i], ob, ol, ok);
            checks++; if (ok !== 1'b1 || ob !== ct[i] || ol !== lst[i]) begin
                errors++; $display("FAIL stream_%0d: got ok=%b byte=%h last=%b want 1 %h %b", i, ok, ob, ol, ct[i], lst[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ob; logic ol; bit ok; int n;
        n = 0;
        while (exp_count != 4'd15 && n < 20) begin
            run_byte(8'h00, 1'b0, 8'hAA, 1, ob, ol, ok);
            n++;
        end
        checks++; if (byte_count !== 4'd15) begin errors++; $display("FAIL wrap_preload: got %0d want 15", byte_count); end
        run_byte(8'h55, 1'b0, 8'hAA, 1, ob, ol, ok);
        checks++; if (byte_count !== 4'd0 || ob !== 8'hFF) begin
            errors++; $display("FAIL wrap_zero: got count=%0d byte=%h want 0 ff", byte_count, ob); end
    endtask

    task automatic test_reset_mid();
        int rq0;
        in_valid = 1'b1; in_byte = 8'hC3; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || hash_req !== 1'b0 || out_valid !== 1'b0 || byte_count !== 4'd0 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL async_reset: got rdy=%b req=%b ov=%b cnt=%0d err=%b want 1 0 0 0 0", in_ready, hash_req, out_valid, byte_count, err_timeout); end
        exp_count = '0;
        step();
        rst_n = 1'b1;
        rq0 = req_cnt;
        step();
        hash_valid = 1'b1; hash_byte = 8'h3C;
        step();
        hash_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_byte !== 8'h00) begin
            errors++; $display("FAIL late_hash_ignored: got ov=%b rdy=%b byte=%h want 0 1 00", out_valid, in_ready, out_byte); end
        checks++; if (req_cnt - rq0 !== 0 || hash_reseed !== 1'b0) begin
            errors++; $display("FAIL reset_no_pulse: got req=%0d reseed=%b want 0 0", req_cnt - rq0, hash_reseed); end
    endtask

    initial begin
        test_reset();
        test_ignored_inputs();
        test_basic();
        test_reseed();
        test_timeout();
        test_timeout_race();
        test_stall();
        test_stream();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cipher_sequencer.md
# cipher_sequencer

Controller that sequences one plaintext byte at a time through the stream cipher: accepts a byte from the interface side, requests one keystream byte from the hash generator, XORs them, and presents the result to the output side. Sits between the I/O interface, the hash generator and the output holder. Reseeds the generator when it reports exhaustion and traps a hung generator with a timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in SQ_AWAIT before error; must be ≥ 2.
- COUNT_W, 16: width of byte_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  plaintext byte offered.
- in_byte  in  8  plaintext byte.
- in_last  in  1  byte is last of message.
- in_ready  out  1  sequencer can accept a byte.
- hash_req  out  1  one-cycle request for the next keystream byte.
- hash_valid  in  1  one-cycle strobe; hash_byte is valid.
- hash_byte  in  8  keystream byte.
- hash_exhausted  in  1  level; generator marker at end of buffer.
- hash_reseed  out  1  one-cycle pulse commanding recomputation.
- out_valid  out  1  ciphertext byte held.
- out_byte  out  8  ciphertext byte.
- out_last  out  1  copy of latched in_last.
- out_ready  in  1  downstream accepts.
- byte_count  out  COUNT_W  bytes delivered since reset, wraps mod 2^COUNT_W.
- err_timeout  out  1  high while in SQ_ERROR.
- err_clear  in  1  leaves SQ_ERROR.

## Operation
- States: SQ_IDLE, SQ_RESEED, SQ_REQUEST, SQ_AWAIT, SQ_OUTPUT, SQ_ERROR.
- SQ_IDLE: in_ready=1. On in_valid, latch in_byte/in_last; go to SQ_RESEED if hash_exhausted, else SQ_REQUEST.
- SQ_RESEED: hash_reseed=1 on the first cycle only; wait for hash_exhausted=0, then SQ_REQUEST. Timer runs; expiry → SQ_ERROR.
- SQ_REQUEST: hash_req=1 for exactly this one cycle; timer cleared; → SQ_AWAIT.
- SQ_AWAIT: on hash_valid, register out_byte = latched byte XOR hash_byte, out_last = latched last, → SQ_OUTPUT. Timer increments each cycle; reaching TIMEOUT_CYCLES-1 without hash_valid → SQ_ERROR.
- SQ_OUTPUT: out_valid=1, out_byte/out_last stable until out_valid && out_ready; on that handshake byte_count += 1 (wraps), → SQ_IDLE.
- SQ_ERROR: err_timeout=1, in_ready=0, latched byte discarded; err_clear → SQ_IDLE.
- Boundary rules: hash_valid and timeout expiry in the same cycle → hash_valid wins. hash_valid outside SQ_AWAIT is ignored. in_valid ignored when in_ready=0. err_clear ignored outside SQ_ERROR. hash_exhausted is sampled only in SQ_IDLE and SQ_RESEED.
- hash_req, hash_reseed, in_ready, out_valid and err_timeout are decoded from registered state; no combinational input→output paths.

## Timing
- Reset values: state SQ_IDLE, in_ready=1, all other outputs 0, byte_count=0, timer=0.
- Reset mid-operation: immediate return to SQ_IDLE; no request or reseed pulse is issued; any pending byte is lost.
- in handshake at edge T → hash_req high in cycle T+1 → SQ_AWAIT from T+2. hash_valid in cycle T+k (k≥2) → out_valid from T+k+1.
- Minimum in→out latency is 3 cycles. Minimum per-byte throughput is 4 cycles plus output stall.
- in_ready re-asserts the cycle after the output handshake.
- The reseed path adds 1 cycle plus the generator's de-assert time.

## Structure
- Add sequencer_state_t (3-bit enum, SQ_IDLE=3'b000 … SQ_ERROR=3'b101) to types_pkg alongside the existing cipher state enums.
- One sub-module: seq_timeout_timer. It is a clearable up-counter with an expiry flag, parameterised by TIMEOUT_CYCLES, and is shared by SQ_RESEED and SQ_AWAIT.

## Test plan
- Reset, then in_byte=8'hA5; hash_byte=8'h3C two cycles after hash_req; out_ready=1 → out_byte=8'h99, byte_count=1, in_ready high again after the handshake.
- hash_exhausted=1 at accept → exactly one hash_reseed pulse. Drop exhausted 3 cycles later → single hash_req, then normal output.
- No hash_valid → err_timeout rises TIMEOUT_CYCLES cycles after SQ_AWAIT entry. err_clear → SQ_IDLE with in_ready=1 and byte_count unchanged.
- Hold out_ready=0 for 10 cycles → out_byte/out_valid stable, no extra hash_req, count increments once on release.
- Stream 3 bytes with in_last on the third → out_last only on the third. Preload byte_count=2^COUNT_W-1 via traffic (reduce COUNT_W=4) → wraps to 0.
- Assert rst_n low during SQ_AWAIT → outputs return to reset values asynchronously. A late hash_valid after reset is ignored.
